// File: rtl/au_arbiter.sv
// Round-robin arbiter granting two requesters time-shared access to one external AU.
// A granted operation holds the AU operands for WAIT_CYCLES edges, then captures the result.
module au_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic [2:0] mode0,
    input  logic [2:0] mode1,
    output logic [3:0] au_a,
    output logic [3:0] au_b,
    output logic [1:0] au_s,
    output logic       au_cin,
    input  logic [3:0] au_d,
    input  logic       au_cout,
    output logic [4:0] res,
    output logic       ack0,
    output logic       ack1,
    output logic       busy,
    output logic       owner,
    output logic [7:0] ops_done
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned OPS_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [3:0]         au_a_nx, au_b_nx;
    logic [1:0]         au_s_nx;
    logic               au_cin_nx;
    logic [4:0]         res_nx;
    logic               ack0_nx, ack1_nx, busy_nx, owner_nx;
    logic [OPS_W-1:0]   ops_done_nx;
    logic               rr_last, rr_last_nx;
    logic               grant;

    // Next-state and registered-output logic
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        au_a_nx     = au_a;
        au_b_nx     = au_b;
        au_s_nx     = au_s;
        au_cin_nx   = au_cin;
        res_nx      = res;
        ack0_nx     = 1'b0;
        ack1_nx     = 1'b0;
        busy_nx     = busy;
        owner_nx    = owner;
        ops_done_nx = ops_done;
        rr_last_nx  = rr_last;
        grant       = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that lost most recently wins
                    grant                = (req0 && req1) ? ~rr_last : req1;
                    owner_nx             = grant;
                    rr_last_nx           = grant;
                    au_a_nx              = grant ? a1 : a0;
                    au_b_nx              = grant ? b1 : b0;
                    {au_s_nx, au_cin_nx} = grant ? mode1 : mode0;
                    cnt_nx               = CNT_W'(WAIT_CYCLES);
                    busy_nx              = 1'b1;
                    state_nx             = RUN;
                end
            end
            RUN: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    res_nx      = {au_cout, au_d};
                    ack0_nx     = ~owner;
                    ack1_nx     = owner;
                    ops_done_nx = ops_done + OPS_W'(1);
                    state_nx    = DONE;
                end
            end
            DONE: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // State register; pointer resets to 1 so requester 0 wins the first tie
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            au_a     <= '0;
            au_b     <= '0;
            au_s     <= '0;
            au_cin   <= 1'b0;
            res      <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
            owner    <= 1'b0;
            ops_done <= '0;
            rr_last  <= 1'b1;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            au_a     <= au_a_nx;
            au_b     <= au_b_nx;
            au_s     <= au_s_nx;
            au_cin   <= au_cin_nx;
            res      <= res_nx;
            ack0     <= ack0_nx;
            ack1     <= ack1_nx;
            busy     <= busy_nx;
            owner    <= owner_nx;
            ops_done <= ops_done_nx;
            rr_last  <= rr_last_nx;
        end
    end

endmodule

// File: tb/tb_au_arbiter.sv
// Scoreboard bench for au_arbiter: a transaction-level model predicts grants and results,
// a separate monitor compares each ack against the predicted queue.
module tb_au_arbiter;

    localparam int unsigned WAIT = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [2:0] mode0 = '0, mode1 = '0;
    logic [3:0] au_a, au_b, au_d;
    logic [1:0] au_s;
    logic       au_cin, au_cout;
    logic [4:0] res;
    logic       ack0, ack1, busy, owner;
    logic [7:0] ops_done;

    au_arbiter #(.WAIT_CYCLES(WAIT)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .mode0(mode0), .mode1(mode1),
        .au_a(au_a), .au_b(au_b), .au_s(au_s), .au_cin(au_cin),
        .au_d(au_d), .au_cout(au_cout),
        .res(res), .ack0(ack0), .ack1(ack1),
        .busy(busy), .owner(owner), .ops_done(ops_done)
    );

    always #5 CLK = ~CLK;

    // Shared AU: adder with a second operand selected by au_s
    logic [3:0] opb;
    always_comb begin
        opb = au_b;
        case (au_s)
            2'd0: opb = au_b;
            2'd1: opb = ~au_b;
            2'd2: opb = 4'd0;
            default: opb = 4'hF;
        endcase
    end
    assign {au_cout, au_d} = 5'(au_a) + 5'(opb) + 5'(au_cin);

    typedef struct {
        logic       who;
        logic [4:0] res;
        int         ack_edge;
        logic [7:0] ops;
    } exp_t;

    exp_t q[$];
    int   edge_n = 0;
    int   n_total = 0;
    int   n_pass = 0;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edge_n);
    endtask

    function automatic logic [4:0] golden(input logic [2:0] m, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] ax, bx, nb;
        ax = {1'b0, a};
        bx = {1'b0, b};
        nb = {1'b0, ~b};
        case (m)
            3'd0: return ax + bx;
            3'd1: return ax + bx + 5'd1;
            3'd2: return ax + nb;
            3'd3: return ax + nb + 5'd1;
            3'd4: return ax;
            3'd5: return ax + 5'd1;
            3'd6: return ax + 5'd15;
            default: return {1'b1, a};
        endcase
    endfunction

    // Reference model: the block is free again WAIT+2 edges after each grant
    initial begin : model
        int         free_edge;
        logic       last_win;
        logic [7:0] ops;
        logic       w;
        exp_t       e;
        free_edge = 0;
        last_win  = 1'b1;
        ops       = '0;
        forever begin
            @(posedge CLK);
            edge_n++;
            if (RST) begin
                q.delete();
                free_edge = edge_n + 1;
                last_win  = 1'b1;
                ops       = '0;
            end else if (edge_n >= free_edge && (req0 || req1)) begin
                w          = (req0 && req1) ? ~last_win : req1;
                e.who      = w;
                e.res      = w ? golden(mode1, a1, b1) : golden(mode0, a0, b0);
                e.ack_edge = edge_n + int'(WAIT);
                e.ops      = ops + 8'd1;
                q.push_back(e);
                ops        = ops + 8'd1;
                last_win   = w;
                free_edge  = edge_n + int'(WAIT) + 2;
            end
        end
    end

    // Monitor: compares every ack pulse against the oldest prediction
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            while (q.size() > 0 && q[0].ack_edge < edge_n) begin
                e = q.pop_front();
                check("missing_ack_at_edge", 0, e.ack_edge);
            end
            if (ack0 || ack1) begin
                if (q.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("ack_both_high", int'(ack0 && ack1), 0);
                    check("ack_requester", int'(ack1), int'(e.who));
                    check("res", int'(res), int'(e.res));
                    check("owner", int'(owner), int'(e.who));
                    check("ack_edge", edge_n, e.ack_edge);
                    check("ops_done", int'(ops_done), int'(e.ops));
                end
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ack(input int which);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge CLK);
            if ((which == 0 && ack0) || (which == 1 && ack1) || (which == 2 && (ack0 || ack1)))
                seen = 1'b1;
        end
        if (!seen) check("ack_timeout", 0, 1);
    endtask

    initial begin : stim
        bit seen;
        // Reset values
        tick;
        tick;
        @(negedge CLK);
        check("rst_au_a", int'(au_a), 0);
        check("rst_au_b", int'(au_b), 0);
        check("rst_au_s", int'(au_s), 0);
        check("rst_au_cin", int'(au_cin), 0);
        check("rst_res", int'(res), 0);
        check("rst_ack", int'({ack0, ack1}), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_owner", int'(owner), 0);
        check("rst_ops_done", int'(ops_done), 0);

        // Single op: 0101 + 0011
        tick;
        RST = 1'b0;
        req0 = 1'b1; a0 = 4'b0101; b0 = 4'b0011; mode0 = 3'b000;
        wait_ack(0);
        tick;
        req0 = 1'b0;
        @(negedge CLK);
        check("busy_after_done", int'(busy), 0);

        // Operand change after grant must not affect the result
        tick;
        req0 = 1'b1; a0 = 4'hF; b0 = 4'h0; mode0 = 3'b101;
        tick;
        a0 = 4'h0;
        wait_ack(0);
        tick;
        req0 = 1'b0;

        // Tie from reset: grants alternate starting with requester 0
        RST = 1'b1;
        tick;
        RST = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        a1 = 4'h7; b1 = 4'h9; mode1 = 3'b010;
        repeat (8) wait_ack(2);
        tick;
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick;

        // Reset in the middle of an operation
        req0 = 1'b1; a0 = 4'h2; b0 = 4'h2; mode0 = 3'b000;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (busy) seen = 1'b1;
        end
        if (!seen) check("grant_timeout", 0, 1);
        RST = 1'b1;
        tick;
        RST = 1'b0;
        @(negedge CLK);
        check("midop_rst_ack", int'({ack0, ack1}), 0);
        check("midop_rst_busy", int'(busy), 0);
        check("midop_rst_ops", int'(ops_done), 0);
        wait_ack(0);
        tick;
        req0 = 1'b0;
        repeat (2) tick;

        // Full mode/operand sweep through requester 1
        for (int m = 0; m < 8; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    a1 = 4'(a); b1 = 4'(b); mode1 = 3'(m); req1 = 1'b1;
                    wait_ack(1);
                    tick;
                end
            end
        end
        req1 = 1'b0;
        repeat (3) tick;

        // Counter wrap after 256 completions
        RST = 1'b1;
        tick;
        RST = 1'b0;
        req0 = 1'b1; a0 = 4'h3; b0 = 4'h4; mode0 = 3'b001;
        for (int i = 1; i <= 256; i++) begin
            wait_ack(0);
            if (i == 255) check("ops_done_255", int'(ops_done), 255);
            if (i == 256) check("ops_done_wrap", int'(ops_done), 0);
        end
        tick;
        req0 = 1'b0;
        repeat (3) tick;

        // Random traffic, including protocol violations and occasional resets
        repeat (800) begin
            tick;
            if ($urandom_range(3) == 0) req0 = ~req0;
            if ($urandom_range(3) == 0) req1 = ~req1;
            a0 = 4'($urandom); b0 = 4'($urandom); mode0 = 3'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom); mode1 = 3'($urandom);
            RST = ($urandom_range(96) == 0);
        end
        tick;
        RST = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (WAIT + 6) tick;
        check("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
